mux_2x1_select_arbiter: RTL and testbench
=========================================

# mux_2X1_select_arbiter

Upstream control stage for the 2X1 mux: arbitrates between two requesters (path a, path b) and drives the mux select `s` plus per-path grants. Round-robin with a bounded hold, so a continuously requesting path cannot starve the other. All outputs are registered; the mux datapath stays purely combinational downstream.

## Interface
- HOLD_MAX, 4: maximum contested cycles an owner keeps the grant while the other path requests; legal range 1..2^CNT_W-1
- CNT_W, 3: width of the contention counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- req_a  input  1  path a requests the mux
- req_b  input  1  path b requests the mux
- sel  output  1  mux select; 0 = a, 1 = b; connects to mux `s`
- gnt_a  output  1  path a owns the mux
- gnt_b  output  1  path b owns the mux
- busy  output  1  a grant is active
- hold_cnt  output  CNT_W  contested cycles used by the current owner

## Operation
- States: IDLE, OWN_A, OWN_B. `gnt_a` = OWN_A, `gnt_b` = OWN_B, `busy` = not IDLE. Grants are one-hot or all-zero.
- Priority pointer `last` (internal, 1 bit): last path granted. Reset value is b, so A wins the first tie.
- IDLE:
  - both requests -> grant the path not equal to `last`
  - one request -> grant that path
  - no request -> stay in IDLE
- OWN_A, symmetric for OWN_B:
  - !req_a and req_b -> OWN_B
  - !req_a and !req_b -> IDLE
  - req_a and req_b and hold_cnt == HOLD_MAX-1 -> OWN_B (forced handover)
  - otherwise -> stay
- Handover A<->B is direct, with no IDLE bubble.
- hold_cnt behaviour:
  - cleared to 0 on every grant entry, including direct handover
  - while staying in an owner state, increments when the other request is high and holds otherwise
  - never exceeds HOLD_MAX-1
  - cleared in IDLE
- Uncontested owner keeps the grant indefinitely.
- `last` updates on every grant entry.
- sel: 0 in OWN_A, 1 in OWN_B. In IDLE it retains its previous value so the mux output does not glitch on release.
- HOLD_MAX = 1: every contested cycle hands over, so grants alternate each cycle.

## Timing
- All state and outputs update on the rising edge of `clk`, except reset.
- Reset values, applied immediately on rst_n low and independent of clk: state IDLE, sel 0, gnt_a 0, gnt_b 0, busy 0, hold_cnt 0, last = b.
- Reset asserted mid-grant: grants drop immediately. The first edge after rst_n rises evaluates requests from IDLE.
- Request-to-grant latency is 1 cycle: request sampled at edge N, grant visible after edge N.
- Release latency is 1 cycle: owner's req low at edge N, grant low, or switched to the other path, after edge N.
- `sel` and `gnt_*` change on the same edge. The consumer must treat the mux output as valid for a path only while that path's gnt is high.
- A request dropping and reasserting within the same cycle is invisible; only sampled levels matter.

## Test plan
- Reset, then req_a=1 only at edge 1 -> after edge 1: gnt_a=1, sel=0, busy=1, hold_cnt=0. Drop req_a -> next edge: IDLE, sel stays 0.
- From IDLE after reset, req_a=req_b=1 at the same edge -> gnt_a=1 (last=b). Release A with B still high -> next edge gnt_b=1, sel=1, no IDLE cycle.
- HOLD_MAX=4, req_a and req_b held high continuously:
  - A owns 4 contested cycles (hold_cnt 0,1,2,3), then B owns 4, and so on
  - sel toggles every 4 cycles
  - gnt_a and gnt_b never both 1
- req_b held alone for 20 cycles -> hold_cnt stays 0 and gnt_b stays 1. req_a rises -> B keeps the grant exactly 4 more edges, then OWN_A.
- Assert rst_n=0 mid-cycle while gnt_b=1 and hold_cnt=2 -> outputs go to reset values without a clock edge. Deassert with req_b=1 -> gnt_b=1 after the next edge.
- HOLD_MAX=1, both requests high -> grant alternates A,B,A,B on every edge; hold_cnt stays 0.

Source files
------------

// File: rtl/mux_2x1_select_arbiter.sv
// mux_2x1_select_arbiter
// Round-robin arbiter in front of a 2:1 mux. It grants one of two requesters
// and drives the mux select. An owner that keeps requesting while the other
// path also requests keeps the grant for at most HOLD_MAX such contested
// cycles and then hands over directly. All outputs are registered.
//
// Parameters
//   HOLD_MAX  contested cycles an owner may keep the grant (1..2^CNT_W-1)
//   CNT_W     width of the contention counter
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_a     path a requests the mux
//   req_b     path b requests the mux
//   sel       mux select, 0 = a, 1 = b (held through IDLE)
//   gnt_a     path a owns the mux
//   gnt_b     path b owns the mux
//   busy      a grant is active
//   hold_cnt  contested cycles used by the current owner
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant; sel keeps the last owner's value
// OWN_A | path a owns the mux, sel = 0
// OWN_B | path b owns the mux, sel = 1

module mux_2x1_select_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t state;
    state_t state_nxt;
    logic   last;          // last path granted: 0 = a, 1 = b
    logic   contested;     // the non-owning path is requesting

    always_comb begin
        state_nxt = state;
        contested = 1'b0;
        case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = last ? OWN_A : OWN_B;
                else if (req_a)
                    state_nxt = OWN_A;
                else if (req_b)
                    state_nxt = OWN_B;
            end
            OWN_A: begin
                contested = req_b;
                if (!req_a)
                    state_nxt = req_b ? OWN_B : IDLE;
                else if (req_b && (hold_cnt == HOLD_LAST))
                    state_nxt = OWN_B;
            end
            OWN_B: begin
                contested = req_a;
                if (!req_b)
                    state_nxt = req_a ? OWN_A : IDLE;
                else if (req_a && (hold_cnt == HOLD_LAST))
                    state_nxt = OWN_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            sel      <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            gnt_a <= (state_nxt == OWN_A);
            gnt_b <= (state_nxt == OWN_B);
            busy  <= (state_nxt != IDLE);

            if (state_nxt == OWN_A)
                sel <= 1'b0;
            else if (state_nxt == OWN_B)
                sel <= 1'b1;

            if ((state_nxt != state) && (state_nxt == OWN_A))
                last <= 1'b0;
            else if ((state_nxt != state) && (state_nxt == OWN_B))
                last <= 1'b1;

            // Staying under contention implies hold_cnt < HOLD_LAST, so the
            // increment cannot pass HOLD_MAX-1.
            if ((state_nxt == IDLE) || (state_nxt != state))
                hold_cnt <= '0;
            else if (contested)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2x1_select_arbiter.sv
// Scoreboard bench for mux_2x1_select_arbiter. One instance uses HOLD_MAX=4,
// a second uses HOLD_MAX=1. Stimulus pushes hand-computed expectations into
// per-instance queues; a monitor on the falling edge pops and compares.

module tb_mux_2x1_select_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic req_a, req_b;
    logic req2_a, req2_b;

    logic       sel, gnt_a, gnt_b, busy;
    logic [2:0] hold_cnt;
    logic       sel2, gnt2_a, gnt2_b, busy2;
    logic [2:0] hold2_cnt;

    typedef struct {
        logic [6:0] v;      // {sel, gnt_a, gnt_b, busy, hold_cnt[2:0]}
        string      name;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mux_2x1_select_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .hold_cnt(hold_cnt)
    );

    mux_2x1_select_arbiter #(.HOLD_MAX(1), .CNT_W(3)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .req_a(req2_a), .req_b(req2_b),
        .sel(sel2), .gnt_a(gnt2_a), .gnt_b(gnt2_b), .busy(busy2),
        .hold_cnt(hold2_cnt)
    );

    function automatic logic [6:0] ex(input logic s, input logic ga,
                                      input logic gb, input logic bz,
                                      input int h);
        return {s, ga, gb, bz, 3'(h)};
    endfunction

    // Monitor: compares whatever the stimulus has queued at each falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        if (q1.size() > 0) begin
            e   = q1.pop_front();
            act = {sel, gnt_a, gnt_b, busy, hold_cnt};
            total++;
            if (act === e.v) passed++;
            else $display("FAIL %s (hold4): got sel/ga/gb/busy/hold=%b, expected %b",
                          e.name, act, e.v);
        end
        if (q2.size() > 0) begin
            e   = q2.pop_front();
            act = {sel2, gnt2_a, gnt2_b, busy2, hold2_cnt};
            total++;
            if (act === e.v) passed++;
            else $display("FAIL %s (hold1): got sel/ga/gb/busy/hold=%b, expected %b",
                          e.name, act, e.v);
        end
    end

    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // queues the expectation for the next falling edge.
    task automatic step(input logic ra, input logic rb,
                        input logic [6:0] ev, input string nm);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        #1;
        q1.push_back('{ev, nm});
        @(negedge clk);
    endtask

    task automatic step2(input logic ra, input logic rb,
                         input logic [6:0] ev, input string nm);
        req2_a = ra;
        req2_b = rb;
        @(posedge clk);
        #1;
        q2.push_back('{ev, nm});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        req2_a = 1'b0;
        req2_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        req2_a = 1'b0;
        req2_b = 1'b0;
        #1;
        q1.push_back('{ex(0, 0, 0, 0, 0), "reset_values"});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then release: sel stays at 0 in IDLE.
        step(1, 0, ex(0, 1, 0, 1, 0), "a_only_grant");
        step(0, 0, ex(0, 0, 0, 0, 0), "a_release_idle");

        // Tie from reset goes to A; release A with B high hands over directly.
        do_reset();
        step(1, 1, ex(0, 1, 0, 1, 0), "tie_a_first");
        step(0, 1, ex(1, 0, 1, 1, 0), "direct_handover_b");
        step(0, 0, ex(1, 0, 0, 0, 0), "idle_sel_holds_b");

        // Continuous contention: 4 cycles each, hold_cnt 0..3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic ob;
            ob = ((i / 4) % 2) == 1;
            step(1, 1, ex(ob, !ob, ob, 1, i % 4), "contend_h4");
        end
        step(0, 0, ex(1, 0, 0, 0, 0), "contend_release_sel");

        // B alone for 20 cycles, then A joins.
        do_reset();
        for (int i = 0; i < 20; i++)
            step(0, 1, ex(1, 0, 1, 1, 0), "b_uncontested");
        step(1, 1, ex(1, 0, 1, 1, 1), "b_hold_1");
        step(1, 1, ex(1, 0, 1, 1, 2), "b_hold_2");
        step(1, 1, ex(1, 0, 1, 1, 3), "b_hold_3");
        step(1, 1, ex(0, 1, 0, 1, 0), "forced_to_a");
        step(1, 1, ex(0, 1, 0, 1, 1), "a_hold_1");
        step(1, 1, ex(0, 1, 0, 1, 2), "a_hold_2");
        step(1, 1, ex(0, 1, 0, 1, 3), "a_hold_3");
        step(1, 1, ex(1, 0, 1, 1, 0), "forced_to_b");
        step(1, 1, ex(1, 0, 1, 1, 1), "b2_hold_1");
        step(1, 1, ex(1, 0, 1, 1, 2), "b2_hold_2");
        // A drops: B stays uncontested with hold_cnt frozen at 2.
        step(0, 1, ex(1, 0, 1, 1, 2), "b_hold_frozen");

        // Asynchronous reset between edges, checked before the next edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q1.push_back('{ex(0, 0, 0, 0, 0), "async_reset_mid_grant"});
        @(negedge clk);
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b1;
        rst_n = 1'b1;
        step(0, 1, ex(1, 0, 1, 1, 0), "post_reset_b");
        step(0, 0, ex(1, 0, 0, 0, 0), "post_reset_release");

        // HOLD_MAX=1: grants alternate every edge.
        for (int i = 0; i < 6; i++) begin
            logic ob;
            ob = (i % 2) == 1;
            step2(1, 1, ex(ob, !ob, ob, 1, 0), "alternate_h1");
        end
        step2(0, 0, ex(1, 0, 0, 0, 0), "h1_release_sel");

        @(negedge clk);
        @(negedge clk);
        total++;
        if ((q1.size() + q2.size()) == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0",
                      q1.size() + q2.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
